// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - shares the single data-memory/DRAM port between the core MEM stage and the IO loader
//
// One outstanding transaction at a time: IDLE accepts a request, BUSY drives the
// DRAM port until ready_dram (or the watchdog expires), HOLD keeps the response
// until the owning requester acknowledges it.
//
// Build option: DRAM_ARB_ROUND_ROBIN_EN
//   defined   - ties go to the requester that was not granted last
//   undefined - fixed priority, mem wins every tie
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   mem_req_valid/we/addr/wdata    core request in
//   mem_req_ready                  core request accepted (combinational)
//   mem_resp_valid/rdata           core completion / read data out
//   mem_resp_ack                   core consumes the response
//   io_*                           same set for the IO loader
//   addr_dram/din_dram/rw_dram/valid_dram   DRAM request out
//   dout_dram/ready_dram           DRAM read data / completion pulse in
//   timeout_err                    sticky watchdog error
module dram_port_arbiter #(
  parameter int ADDR_W  = 27,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              mem_req_valid,
  input  logic              mem_req_we,
  input  logic [31:0]       mem_req_addr,
  input  logic [31:0]       mem_req_wdata,
  output logic              mem_req_ready,
  output logic              mem_resp_valid,
  output logic [31:0]       mem_resp_rdata,
  input  logic              mem_resp_ack,

  input  logic              io_req_valid,
  input  logic              io_req_we,
  input  logic [31:0]       io_req_addr,
  input  logic [31:0]       io_req_wdata,
  output logic              io_req_ready,
  output logic              io_resp_valid,
  output logic [31:0]       io_resp_rdata,
  input  logic              io_resp_ack,

  output logic [ADDR_W-1:0] addr_dram,
  output logic [31:0]       din_dram,
  output logic              rw_dram,
  output logic              valid_dram,
  input  logic [31:0]       dout_dram,
  input  logic              ready_dram,

  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Counter value during the last BUSY cycle the watchdog allows.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic             grant_io;       // owner of the current transaction: 1 = io, 0 = mem
  logic             last_grant_io;  // owner of the last completed transaction
  logic [CNT_W-1:0] wd_cnt;

  logic             mem_wins_tie;
  logic             mem_win;
  logic             io_win;
  logic             owner_ack;

  // Only the low ADDR_W address bits reach the DRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_req_addr[31:ADDR_W], io_req_addr[31:ADDR_W]};

`ifdef DRAM_ARB_ROUND_ROBIN_EN
  // Whoever was not served last gets the tie.
  assign mem_wins_tie = last_grant_io;
`else
  // Fixed priority; last_grant_io is tracked but does not steer anything.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_io;
  assign mem_wins_tie = 1'b1;
`endif

  assign mem_win = (state == IDLE) && mem_req_valid && (!io_req_valid || mem_wins_tie);
  assign io_win  = (state == IDLE) && io_req_valid && !(mem_req_valid && mem_wins_tie);

  assign mem_req_ready = mem_win;
  assign io_req_ready  = io_win;

  // Only the owner's ack can retire a held response.
  assign owner_ack = grant_io ? io_resp_ack : mem_resp_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      grant_io       <= 1'b0;
      last_grant_io  <= 1'b1;
      wd_cnt         <= '0;
      addr_dram      <= '0;
      din_dram       <= '0;
      rw_dram        <= 1'b0;
      valid_dram     <= 1'b0;
      mem_resp_valid <= 1'b0;
      mem_resp_rdata <= '0;
      io_resp_valid  <= 1'b0;
      io_resp_rdata  <= '0;
      timeout_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_win || io_win) begin
            grant_io   <= io_win;
            rw_dram    <= io_win ? io_req_we : mem_req_we;
            addr_dram  <= io_win ? io_req_addr[ADDR_W-1:0] : mem_req_addr[ADDR_W-1:0];
            din_dram   <= io_win ? io_req_wdata : mem_req_wdata;
            valid_dram <= 1'b1;
            wd_cnt     <= '0;
            state      <= BUSY;
          end
        end

        BUSY: begin
          // ready_dram takes precedence over a watchdog expiry in the same cycle.
          if (ready_dram || (wd_cnt == CNT_LAST)) begin
            if (!rw_dram) begin
              // An aborted read returns zero.
              if (grant_io) begin
                io_resp_rdata <= ready_dram ? dout_dram : 32'd0;
              end else begin
                mem_resp_rdata <= ready_dram ? dout_dram : 32'd0;
              end
            end
            if (!ready_dram) begin
              timeout_err <= 1'b1;
            end
            if (grant_io) begin
              io_resp_valid <= 1'b1;
            end else begin
              mem_resp_valid <= 1'b1;
            end
            valid_dram <= 1'b0;
            wd_cnt     <= '0;
            state      <= HOLD;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        HOLD: begin
          if (owner_ack) begin
            mem_resp_valid <= 1'b0;
            io_resp_valid  <= 1'b0;
            last_grant_io  <= grant_io;
            state          <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb/tb_dram_port_arbiter.sv - self-checking scoreboard bench for dram_port_arbiter
`timescale 1ns/1ps
module tb_dram_port_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid, mem_req_we, mem_req_ready, mem_resp_valid, mem_resp_ack;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
  logic        io_req_valid, io_req_we, io_req_ready, io_resp_valid, io_resp_ack;
  logic [31:0] io_req_addr, io_req_wdata, io_resp_rdata;
  logic [26:0] addr_dram;
  logic [31:0] din_dram, dout_dram;
  logic        rw_dram, valid_dram, ready_dram, timeout_err;

  dram_port_arbiter #(.ADDR_W(27), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata), .mem_resp_ack(mem_resp_ack),
    .io_req_valid(io_req_valid), .io_req_we(io_req_we), .io_req_addr(io_req_addr),
    .io_req_wdata(io_req_wdata), .io_req_ready(io_req_ready), .io_resp_valid(io_resp_valid),
    .io_resp_rdata(io_resp_rdata), .io_resp_ack(io_resp_ack),
    .addr_dram(addr_dram), .din_dram(din_dram), .rw_dram(rw_dram), .valid_dram(valid_dram),
    .dout_dram(dout_dram), .ready_dram(ready_dram), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_io;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] mdl_mem_rdata = '0;
  logic [31:0] mdl_io_rdata = '0;
  logic        mdl_to = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit io, input bit v, input bit we, input logic [31:0] a, input logic [31:0] wd);
    if (io) begin
      io_req_valid = v; io_req_we = we; io_req_addr = a; io_req_wdata = wd;
    end else begin
      mem_req_valid = v; mem_req_we = we; mem_req_addr = a; mem_req_wdata = wd;
    end
  endtask

  // Entered just after a rising edge with the arbiter in IDLE and requests set up.
  // dly = BUSY cycle index (0-based) carrying ready_dram, negative = never.
  // Returns just after the rising edge that brings the arbiter back to IDLE.
  task automatic txn(input bit exp_io, input bit drop, input int dly, input logic [31:0] dout, input int hold);
    exp_t        e;
    exp_t        got;
    logic        we;
    logic [31:0] a, wd;
    we = exp_io ? io_req_we : mem_req_we;
    a  = exp_io ? io_req_addr : mem_req_addr;
    wd = exp_io ? io_req_wdata : mem_req_wdata;

    @(negedge clk);
    check("idle_mem_resp_valid", mem_resp_valid, 0);
    check("idle_io_resp_valid", io_resp_valid, 0);
    check("grant_mem_req_ready", mem_req_ready, !exp_io);
    check("grant_io_req_ready", io_req_ready, exp_io);

    if (!we) begin
      if (exp_io) mdl_io_rdata = (dly < 0) ? 32'd0 : dout;
      else        mdl_mem_rdata = (dly < 0) ? 32'd0 : dout;
    end
    if (dly < 0) mdl_to = 1'b1;
    e.is_io = exp_io;
    e.rdata = exp_io ? mdl_io_rdata : mdl_mem_rdata;
    sb.push_back(e);

    step();
    if (drop) begin
      if (exp_io) io_req_valid = 1'b0;
      else        mem_req_valid = 1'b0;
    end

    for (int i = 0; i < TO; i++) begin
      ready_dram = (i == dly);
      dout_dram  = (i == dly) ? dout : 32'hDEAD_BEEF;
      @(negedge clk);
      check("busy_valid_dram", valid_dram, 1);
      check("busy_addr_dram", addr_dram, a & 32'h07FF_FFFF);
      check("busy_rw_dram", rw_dram, we);
      check("busy_din_dram", din_dram, wd);
      check("busy_mem_req_ready", mem_req_ready, 0);
      check("busy_io_req_ready", io_req_ready, 0);
      step();
      ready_dram = 1'b0;
      if (i == dly) break;
    end

    if (sb.size() == 0) begin
      check("sb_underflow", 1, 0);
      return;
    end
    got = sb.pop_front();
    for (int h = 0; h <= hold; h++) begin
      // The non-owner acks every HOLD cycle; it must have no effect.
      if (got.is_io) begin io_resp_ack = (h == hold); mem_resp_ack = 1'b1; end
      else           begin mem_resp_ack = (h == hold); io_resp_ack = 1'b1; end
      @(negedge clk);
      check("hold_valid_dram", valid_dram, 0);
      check("hold_timeout_err", timeout_err, mdl_to);
      check("hold_io_resp_valid", io_resp_valid, got.is_io);
      check("hold_mem_resp_valid", mem_resp_valid, !got.is_io);
      check("hold_rdata", got.is_io ? io_resp_rdata : mem_resp_rdata, got.rdata);
      check("hold_mem_req_ready", mem_req_ready, 0);
      check("hold_io_req_ready", io_req_ready, 0);
      step();
    end
    mem_resp_ack = 1'b0;
    io_resp_ack  = 1'b0;
  endtask

  initial begin
    bit exp_io;
    rst = 1'b1;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    mem_resp_ack = 1'b0; io_resp_ack = 1'b0;
    ready_dram = 1'b0; dout_dram = '0;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid_dram", valid_dram, 0);
    check("rst_addr_dram", addr_dram, 0);
    check("rst_din_dram", din_dram, 0);
    check("rst_rw_dram", rw_dram, 0);
    check("rst_mem_resp_valid", mem_resp_valid, 0);
    check("rst_io_resp_valid", io_resp_valid, 0);
    check("rst_mem_resp_rdata", mem_resp_rdata, 0);
    check("rst_io_resp_rdata", io_resp_rdata, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_mem_req_ready", mem_req_ready, 0);
    check("rst_io_req_ready", io_req_ready, 0);
    step();

    // Contention: both held valid for four back-to-back minimum-latency reads.
    set_req(0, 1, 0, 32'h0000_0040, 0);
    set_req(1, 1, 0, 32'h0000_0080, 0);
    for (int k = 0; k < 4; k++) begin
`ifdef DRAM_ARB_ROUND_ROBIN_EN
      exp_io = (k % 2) == 1;
`else
      exp_io = 1'b0;
`endif
      txn(exp_io, 0, 0, 32'hA000_0000 + k, 0);
    end
    mem_req_valid = 1'b0;
    io_req_valid  = 1'b0;

    // mem read, ready 3 cycles after valid_dram rises, held 2 cycles.
    set_req(0, 1, 0, 32'h0000_0100, 0);
    txn(0, 1, 3, 32'hCAFE_0001, 2);
    // mem write with upper address bits set: rdata must keep the last read value.
    set_req(0, 1, 1, 32'hF800_0104, 32'h55AA_55AA);
    txn(0, 1, 0, 32'h1111_2222, 0);
    // io write.
    set_req(1, 1, 1, 32'h0000_0020, 32'h1234_5678);
    txn(1, 1, 2, 32'h3333_4444, 1);

    // mem response held 5 cycles while io waits, then io is served.
    set_req(1, 1, 0, 32'hFFFF_FFF0, 0);
    set_req(0, 1, 0, 32'h0000_0200, 0);
    txn(0, 1, 1, 32'h0BAD_F00D, 5);
    txn(1, 1, 4, 32'h7777_1111, 0);

    // Watchdog expiry, then a read completing on the last allowed cycle.
    set_req(0, 1, 0, 32'h0000_0300, 0);
    txn(0, 1, -1, 32'h9999_9999, 1);
    set_req(1, 1, 0, 32'h0000_0304, 0);
    txn(1, 1, TO - 1, 32'h5A5A_0F0F, 0);

    // Reset two cycles into BUSY; a late ready_dram must be ignored.
    set_req(0, 1, 0, 32'h0000_0400, 0);
    @(negedge clk);
    check("pre_rst_mem_req_ready", mem_req_ready, 1);
    step();
    mem_req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    mdl_mem_rdata = '0; mdl_io_rdata = '0; mdl_to = 1'b0;
    @(negedge clk);
    check("midrst_valid_dram", valid_dram, 0);
    check("midrst_mem_resp_valid", mem_resp_valid, 0);
    check("midrst_io_resp_valid", io_resp_valid, 0);
    check("midrst_timeout_err", timeout_err, 0);
    step();
    ready_dram = 1'b1; dout_dram = 32'hBEEF_0000;
    step();
    ready_dram = 1'b0;
    @(negedge clk);
    check("late_ready_valid_dram", valid_dram, 0);
    check("late_ready_mem_resp_valid", mem_resp_valid, 0);
    check("late_ready_mem_resp_rdata", mem_resp_rdata, 0);
    step();

    // Normal operation after reset.
    set_req(1, 1, 0, 32'h0000_0500, 0);
    txn(1, 1, 0, 32'h0F0F_F0F0, 0);

    @(negedge clk);
    check("end_mem_resp_valid", mem_resp_valid, 0);
    check("end_io_resp_valid", io_resp_valid, 0);
    check("end_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
